// File: rtl/reg_file_alu_ctrl_pkg.sv
// reg_file_alu_ctrl_pkg: opcode, ALU-control and FSM-state types shared by the control unit.
package reg_file_alu_ctrl_pkg;
  typedef enum logic [3:0] {
    OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORI,
    OPC_BEQ, OPC_JMP, OPC_NOPA, OPC_NOPB, OPC_NOPC, OPC_NOPD, OPC_NOPE, OPC_HALT
  } opcode_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_ctrl_e;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_e;
  localparam opcode_e OP_HALT = OPC_HALT;
  localparam opcode_e OP_JMP  = OPC_JMP;
  localparam opcode_e OP_BEQ  = OPC_BEQ;
  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa;
    logic [7:0] imm;
    alu_ctrl_e  alu_ctrl;
    logic       alu_src;
    logic       is_write;
    logic       is_beq;
    logic       is_jmp;
    logic       is_halt;
    logic [3:0] offset;
    logic [7:0] target;
  } dec_t;
endpackage

// File: rtl/reg_file_alu_ctrl_if.sv
// reg_file_alu_ctrl_if: instruction-memory fetch handshake between control unit and memory.
interface reg_file_alu_ctrl_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   imem_valid;
  modport master (output imem_req, imem_addr, input imem_data, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_data, imem_valid);
endinterface

// File: rtl/reg_file_alu_ctrl_decode.sv
// ctrl_instr_decode: combinational split of an instruction word into datapath fields and op class.
module ctrl_instr_decode
  import reg_file_alu_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);
  opcode_e op;
  logic    r_type, i_type, is_alu;
  assign op     = opcode_e'(ir[15:12]);
  assign is_alu = ~ir[15];
  assign r_type = is_alu & ~ir[14];
  assign i_type = is_alu & ir[14];
  always_comb begin
    dec          = '0;
    dec.is_beq   = op == OP_BEQ;
    dec.is_jmp   = op == OP_JMP;
    dec.is_halt  = op == OP_HALT;
    dec.ra1      = (r_type | dec.is_beq) ? ir[7:4] : i_type ? ir[11:8] : 4'h0;
    dec.ra2      = (r_type | dec.is_beq) ? ir[3:0] : 4'h0;
    dec.wa       = is_alu ? ir[11:8] : 4'h0;
    dec.imm      = i_type ? ir[7:0] : 8'h0;
    dec.alu_ctrl = is_alu ? alu_ctrl_e'(ir[13:12]) : dec.is_beq ? ALU_SUB : ALU_ADD;
    dec.alu_src  = i_type;
    dec.is_write = is_alu;
    dec.offset   = dec.is_beq ? ir[11:8] : 4'h0;
    dec.target   = dec.is_jmp ? ir[7:0] : 8'h0;
  end
endmodule

// File: rtl/reg_file_alu_ctrl.sv
// reg_file_alu_ctrl: multi-cycle fetch/decode/exec control unit for the reg_file_alu datapath.
// Define RETIRE_CNT_EN to add the saturating retired_cnt output.
module reg_file_alu_ctrl
  import reg_file_alu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                start,
  reg_file_alu_ctrl_if.master imem,
  input  logic                Zero,
  output logic [3:0]          RA1,
  output logic [3:0]          RA2,
  output logic [3:0]          WA,
  output logic [7:0]          immediate,
  output logic [1:0]          ALUControl,
  output logic                ALUSrc,
  output logic                write_enable,
  output logic                halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [15:0]         retired_cnt
`endif
);
  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc, pc_br;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   imem_req_q, imem_req_d;
  logic                   write_enable_q, write_enable_d;
  logic                   halted_q, halted_d;
  logic                   alu_src_q, alu_src_d;
  logic [3:0]             ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic [7:0]             imm_q, imm_d;
  alu_ctrl_e              alu_q, alu_d;
  dec_t                   dec;
`ifdef RETIRE_CNT_EN
  logic [15:0]            retired_cnt_q, retired_cnt_d;
  assign retired_cnt   = retired_cnt_q;
  assign retired_cnt_d = (state_q == EXEC && retired_cnt_q != 16'hFFFF) ? retired_cnt_q + 16'd1 : retired_cnt_q;
`endif

  ctrl_instr_decode u_dec (.ir(ir_q), .dec(dec));

  assign pc_inc         = pc_q + PC_WIDTH'(1);
  assign pc_br          = pc_inc + {{(PC_WIDTH-4){dec.offset[3]}}, dec.offset};
  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign RA1            = ra1_q;
  assign RA2            = ra2_q;
  assign WA             = wa_q;
  assign immediate      = imm_q;
  assign ALUControl     = alu_q;
  assign ALUSrc         = alu_src_q;
  assign write_enable   = write_enable_q;
  assign halted         = halted_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    imem_req_d     = imem_req_q;
    write_enable_d = 1'b0;
    halted_d       = halted_q;
    ra1_d          = ra1_q;
    ra2_d          = ra2_q;
    wa_d           = wa_q;
    imm_d          = imm_q;
    alu_d          = alu_q;
    alu_src_d      = alu_src_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: if (imem.imem_valid) begin
        ir_d       = imem.imem_data;
        imem_req_d = 1'b0;
        state_d    = DECODE;
      end
      DECODE: begin
        ra1_d          = dec.ra1;
        ra2_d          = dec.ra2;
        wa_d           = dec.wa;
        imm_d          = dec.imm;
        alu_d          = dec.alu_ctrl;
        alu_src_d      = dec.alu_src;
        write_enable_d = dec.is_write;
        state_d        = EXEC;
      end
      EXEC: begin
        state_d    = dec.is_halt ? HALT : FETCH;
        imem_req_d = ~dec.is_halt;
        halted_d   = dec.is_halt;
        // Zero is only meaningful here, while the BEQ compare is on the datapath
        pc_d       = dec.is_halt ? pc_q : dec.is_jmp ? PC_WIDTH'(dec.target) : (dec.is_beq && Zero) ? pc_br : pc_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      ir_q           <= '0;
      imem_req_q     <= 1'b0;
      write_enable_q <= 1'b0;
      halted_q       <= 1'b0;
      ra1_q          <= '0;
      ra2_q          <= '0;
      wa_q           <= '0;
      imm_q          <= '0;
      alu_q          <= ALU_ADD;
      alu_src_q      <= 1'b0;
`ifdef RETIRE_CNT_EN
      retired_cnt_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      imem_req_q     <= imem_req_d;
      write_enable_q <= write_enable_d;
      halted_q       <= halted_d;
      ra1_q          <= ra1_d;
      ra2_q          <= ra2_d;
      wa_q           <= wa_d;
      imm_q          <= imm_d;
      alu_q          <= alu_d;
      alu_src_q      <= alu_src_d;
`ifdef RETIRE_CNT_EN
      retired_cnt_q  <= retired_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_reg_file_alu_ctrl.sv
// tb_reg_file_alu_ctrl: directed + random programs run against an instruction-level reference model.
module tb_reg_file_alu_ctrl;
  logic       clk = 1'b0;
  logic       RESETn, start, Zero;
  logic [3:0] RA1, RA2, WA;
  logic [7:0] immediate;
  logic [1:0] ALUControl;
  logic       ALUSrc, write_enable, halted;
`ifdef RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif
  logic [15:0] mem [256];
  logic [7:0]  env_rf [16] = '{default: 8'h0};
  logic [7:0]  regs_m [16] = '{default: 8'h0};
  logic [7:0]  opa, opb, alu_res;
  logic        rsp_en, spurious;
  int          pc_m, n_chk, n_pass;
  bit          hit;

  reg_file_alu_ctrl_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) imem_if ();

  reg_file_alu_ctrl #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
    .CLK(clk), .RESETn(RESETn), .start(start), .imem(imem_if), .Zero(Zero),
    .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate), .ALUControl(ALUControl),
    .ALUSrc(ALUSrc), .write_enable(write_enable), .halted(halted)
`ifdef RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in datapath: register file + ALU driven by the DUT's outputs
  always_comb begin
    opa     = env_rf[RA1];
    opb     = ALUSrc ? immediate : env_rf[RA2];
    alu_res = ALUControl == 2'd0 ? opa + opb : ALUControl == 2'd1 ? opa - opb :
              ALUControl == 2'd2 ? opa & opb : opa | opb;
  end
  assign Zero = alu_res == 8'h0;
  always @(posedge clk) if (write_enable) env_rf[WA] <= alu_res;

  // Instruction memory: 0..2 cycle random response latency
  initial begin
    int  dly;
    bit  busy;
    busy = 0;
    dly = 0;
    imem_if.imem_valid = 1'b0;
    imem_if.imem_data  = '0;
    forever begin
      @(negedge clk);
      imem_if.imem_valid = spurious;
      if (spurious) imem_if.imem_data = 16'h4FFF;
      if (!imem_if.imem_req || !rsp_en) busy = 0;
      else begin
        if (!busy) begin
          busy = 1;
          dly = $urandom_range(0, 2);
        end
        if (dly == 0) begin
          imem_if.imem_valid = 1'b1;
          imem_if.imem_data  = mem[imem_if.imem_addr];
          busy = 0;
        end else dly--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESETn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    RESETn = 1'b1;
    #1;
    pc_m = 0;
    chk("rst_req", imem_if.imem_req, 0);
    chk("rst_addr", imem_if.imem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_dp", {RA1, RA2, WA, immediate, ALUControl, ALUSrc}, 0);
`ifdef RETIRE_CNT_EN
    chk("rst_retired", retired_cnt, 0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Execute up to max_n instructions, comparing each against the ISA-level model
  task automatic run_prog(input int max_n, output bit halt_seen);
    int          n, op, off;
    bit          v, rt, it, bq;
    logic [15:0] ir;
    logic [7:0]  a, b, res;
    halt_seen = 0;
    for (int k = 0; k < max_n && !halt_seen; k++) begin
      n = 0;
      while (imem_if.imem_req !== 1'b1 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("fetch_req", imem_if.imem_req, 1);
      chk("fetch_addr", imem_if.imem_addr, pc_m);
      ir = mem[pc_m[7:0]];
      n = 0;
      v = 0;
      while (!v && n < 40) begin
        @(posedge clk);
        v = imem_if.imem_valid;
        #1;
        n++;
      end
      chk("fetch_done", v, 1);
      chk("dec_we", write_enable, 0);
      chk("dec_req", imem_if.imem_req, 0);
      @(posedge clk);
      #1;
      op = int'(ir[15:12]);
      rt = op < 4;
      it = op >= 4 && op < 8;
      bq = op == 8;
      chk("ex_ra1", RA1, (rt || bq) ? ir[7:4] : it ? ir[11:8] : 4'h0);
      chk("ex_ra2", RA2, (rt || bq) ? ir[3:0] : 4'h0);
      chk("ex_wa", WA, op < 8 ? ir[11:8] : 4'h0);
      chk("ex_imm", immediate, it ? ir[7:0] : 8'h0);
      chk("ex_aluc", ALUControl, op < 8 ? op % 4 : bq ? 1 : 0);
      chk("ex_alusrc", ALUSrc, it);
      chk("ex_we", write_enable, op < 8);
      chk("ex_halted", halted, 0);
      a = regs_m[it ? ir[11:8] : ir[7:4]];
      b = it ? ir[7:0] : regs_m[ir[3:0]];
      res = op % 4 == 0 ? a + b : op % 4 == 1 ? a - b : op % 4 == 2 ? a & b : a | b;
      off = ir[11] ? int'(ir[11:8]) - 16 : int'(ir[11:8]);
      if (op < 8) begin
        regs_m[ir[11:8]] = res;
        pc_m = (pc_m + 1) % 256;
      end else if (bq) pc_m = (pc_m + 1 + (regs_m[ir[7:4]] == regs_m[ir[3:0]] ? off : 0) + 256) % 256;
      else if (op == 9) pc_m = int'(ir[7:0]);
      else if (op != 15) pc_m = (pc_m + 1) % 256;
      @(posedge clk);
      #1;
      chk("post_we", write_enable, 0);
      if (op == 15) begin
        halt_seen = 1;
        chk("halted", halted, 1);
        chk("halt_req", imem_if.imem_req, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    RESETn = 1'b0;
    start = 1'b0;
    rsp_en = 1'b1;
    spurious = 1'b0;
    pc_m = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[0] = 16'h4105;
    mem[1] = 16'h0312;
    mem[2] = 16'h4204;
    mem[3] = 16'h4201;
    mem[4] = 16'h8E12;
    mem[5] = 16'h90FF;
    mem[255] = 16'hA000;
    do_reset();
    pulse_start();
    run_prog(9, hit);
    rsp_en = 1'b0;
    chk("wrap_addr", imem_if.imem_addr, 0);
    chk("wrap_req", imem_if.imem_req, 1);
    @(posedge clk);
    #1;
    chk("wait_req", imem_if.imem_req, 1);
    #2;
    RESETn = 1'b0;
    #1;
    chk("async_req", imem_if.imem_req, 0);
    chk("async_addr", imem_if.imem_addr, 0);
    pc_m = 0;
    @(negedge clk);
    RESETn = 1'b1;
    @(posedge clk);
    #2 spurious = 1'b1;
    @(posedge clk);
    #2 spurious = 1'b0;
    rsp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("late_valid_req", imem_if.imem_req, 0);
      chk("late_valid_we", write_enable, 0);
    end
    for (int i = 0; i < 256; i++)
      mem[i] = $urandom_range(0, 49) == 0 ? 16'hF000 : {4'($urandom_range(0, 14)), 12'($urandom)};
    pulse_start();
    run_prog(150, hit);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk("regfile", env_rf[i], regs_m[i]);
    do_reset();
    mem[0] = {4'h4, 12'($urandom)};
    mem[1] = {4'($urandom_range(10, 14)), 12'($urandom)};
    mem[2] = 16'hF000;
    pulse_start();
    run_prog(10, hit);
    chk("halt_seen", hit, 1);
`ifdef RETIRE_CNT_EN
    chk("retired3", retired_cnt, 3);
`endif
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_halted", halted, 1);
      chk("hold_req", imem_if.imem_req, 0);
      chk("hold_pc", imem_if.imem_addr, 2);
    end
    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_file_alu_ctrl.md
Name: reg_file_alu_ctrl

Overview:
Multi-cycle control unit that drives the reg_file_alu datapath. Fetches 16-bit instructions from an external instruction memory through a req/valid handshake, then decodes them into RA1/RA2/WA/immediate/ALUControl/ALUSrc/write_enable. Uses the datapath Zero flag to resolve branches, and holds the program counter.

Parameters:
PC_WIDTH, 8, program counter and instruction address width
INSTR_WIDTH, 16, instruction word width; fixed by the encoding below

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves IDLE
imem_req  out  1  fetch request, registered
imem_addr  out  PC_WIDTH  fetch address (= PC)
imem_data  in  16  instruction word, valid when imem_valid
imem_valid  in  1  instruction-memory response strobe
Zero  in  1  datapath ALU zero flag, combinational from the datapath
RA1  out  4  datapath read address 1
RA2  out  4  datapath read address 2
WA  out  4  datapath write address
immediate  out  8  datapath immediate operand
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
ALUSrc  out  1  0 = RD2, 1 = immediate
write_enable  out  1  register-file write strobe
halted  out  1  high in HALT state

Behaviour:
- Encoding: op = [15:12]. R-type ops 0–3 (ADD/SUB/AND/OR): WA = [11:8], RA1 = [7:4], RA2 = [3:0], ALUSrc = 0.
- I-type ops 4–7 (ADDI/SUBI/ANDI/ORI): WA = RA1 = [11:8], immediate = [7:0], ALUSrc = 1.
- Op 8 BEQ: RA1 = [7:4], RA2 = [3:0], ALUControl = SUB; offset = [11:8], 4-bit signed.
- Op 9 JMP: target = [7:0] (low PC_WIDTH bits).
- Op F HALT. Ops A–E are NOPs.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset, asynchronous and immediate:
  - state = IDLE, PC = 0.
  - All datapath outputs = 0; imem_req, write_enable and halted = 0.
  - An outstanding fetch is abandoned; a late imem_valid is ignored.
- IDLE: on start go to FETCH and raise imem_req on the next edge.
- FETCH: imem_req = 1, imem_addr = PC. When imem_valid = 1 at a rising edge, latch imem_data into IR, drop imem_req and go to DECODE.
- imem_valid is ignored in every state other than FETCH. Wait cycles are unbounded.
- DECODE: register the datapath outputs from IR; write_enable stays 0. Go to EXEC.
- EXEC: datapath outputs are held stable.
  - ALU ops: write_enable = 1 for exactly this one cycle; the write happens at the EXEC→FETCH edge. PC ← PC+1.
  - BEQ: Zero is sampled at the end of EXEC. If 1, PC ← PC+1+sext(offset); otherwise PC ← PC+1. write_enable = 0.
  - JMP: PC ← target. NOP: PC ← PC+1.
  - HALT: go to HALT, PC unchanged.
  - Every non-HALT op returns to FETCH.
- Instruction latency: ≥3 cycles (1 FETCH with immediate valid, 1 DECODE, 1 EXEC).
- PC arithmetic is modulo 2^PC_WIDTH: PC 255 + 1 → 0, and a negative offset from 0 wraps.
- Unused output fields for an op: driven 0 (e.g. immediate = 0 for R-type, WA = 0 for BEQ).
- HALT: halted = 1 and all strobes = 0. Only RESETn leaves HALT; start is ignored there.
- start outside IDLE is ignored.

Optional Feature:
- Macro RETIRE_CNT_EN.
- Defined: adds output port retired_cnt[15:0].
  - Reset 0; increments at the end of every EXEC cycle, HALT included.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package reg_file_alu_ctrl_pkg holds:
  - opcode_e, a 4-bit enum of every opcode above;
  - alu_ctrl_e, a 2-bit enum ADD/SUB/AND/OR;
  - state_e, the five FSM states;
  - constants OP_HALT, OP_JMP and OP_BEQ.
- One natural sub-module: ctrl_instr_decode. Purely combinational: IR → {RA1, RA2, WA, immediate, ALUControl, ALUSrc, is_write, is_beq, is_jmp, is_halt, offset, target}.
- The top level keeps the FSM, PC, IR and the handshake.

Test Plan:
- Reset, then start. Memory returns 0x4105 (ADDI R1,5) with a 2-cycle valid delay. Required: imem_addr = 0 during FETCH; in EXEC, WA = 1, RA1 = 1, immediate = 5, ALUSrc = 1, ALUControl = 00; write_enable high for exactly 1 cycle; PC = 1.
- 0x0312 (ADD R3,R1,R2) → RA1 = 1, RA2 = 2, WA = 3, ALUSrc = 0, write_enable pulse; 3 cycles with zero-wait memory.
- BEQ 0x8E12 at PC = 4:
  - Zero = 1 → next imem_addr = 3 (4+1−2).
  - Zero = 0 → next imem_addr = 5.
  - write_enable stays 0 in both cases.
- JMP 0x90FF → next imem_addr = 255. A NOP there → next imem_addr = 0 (wrap).
- 0xF000 → halted = 1, imem_req stays 0, start pulses ignored. Reset → halted = 0, PC = 0, IDLE.
- RESETn asserted mid-FETCH with imem_req = 1 → imem_req drops without waiting for a clock edge. A later imem_valid causes no IR load. With RETIRE_CNT_EN defined: retired_cnt = 0 after reset, 3 after three executed instructions.
